seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 14 +
 rtl/div_counter.sv | 34 +++
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared state encoding and sizing constants for the sequential divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DIV_WIDTH = 16;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/div_counter.sv
// Iteration counter for the divider: loads the step count and counts down to zero.
module div_counter
   import div_pkg::*;
#(
   parameter int CW = DIV_CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          dec,
   input  logic [CW-1:0] load_val,
   output logic          zero,
   output logic          last
);

   logic [CW-1:0] count_r;

   // Load wins over decrement; decrement saturates at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {CW{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (dec && (count_r != {CW{1'b0}})) begin
         count_r <= count_r - CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == {CW{1'b0}});
   assign last = (count_r == CW'(1));

endmodule

// File: rtl/seq_divider.sv
// Signed restoring divider: one quotient bit per cycle on magnitudes, sign fix-up at the end.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t         state_r, state_next_s;
   logic [WIDTH:0] q_r, b_r, r_r;
   logic           sq_r, sr_r, ovf_r;
   logic           accept_s, zero_div_s, ovf_s;
   logic           cnt_load_s, cnt_dec_s, cnt_zero_s, cnt_last_s;
   logic [WIDTH:0] r_shift_s, r_diff_s, q_fix_s, r_fix_s;
   logic           trial_ok_s;

   // The most-negative value needs WIDTH+1 bits to hold its magnitude
   function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] v);
      logic [WIDTH:0] ext;
      ext = {v[WIDTH-1], v};
      mag = v[WIDTH-1] ? ({(WIDTH+1){1'b0}} - ext) : ext;
   endfunction

   assign accept_s   = start && ((state_r == IDLE) || (state_r == DONE));
   assign zero_div_s = (divisor == {WIDTH{1'b0}});
   assign ovf_s      = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == {WIDTH{1'b1}});

   assign r_shift_s  = {r_r[WIDTH-1:0], q_r[WIDTH-1]};
   assign trial_ok_s = (r_shift_s >= b_r);
   assign r_diff_s   = r_shift_s - b_r;
   assign q_fix_s    = sq_r ? ({(WIDTH+1){1'b0}} - q_r) : q_r;
   assign r_fix_s    = sr_r ? ({(WIDTH+1){1'b0}} - r_r) : r_r;

   div_counter #(.CW(CW)) u_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load_s),
      .dec      (cnt_dec_s),
      .load_val (CW'(WIDTH)),
      .zero     (cnt_zero_s),
      .last     (cnt_last_s)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and counter control
   always_comb begin
      state_next_s = state_r;
      cnt_load_s   = 1'b0;
      cnt_dec_s    = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (accept_s) begin
               cnt_load_s   = !zero_div_s;
               state_next_s = zero_div_s ? DONE : ITER;
            end else begin
               state_next_s = state_r;
            end
         end
         ITER: begin
            cnt_dec_s = !cnt_zero_s;
            if (cnt_last_s || cnt_zero_s) begin
               state_next_s = FIX;
            end else begin
               state_next_s = ITER;
            end
         end
         FIX:     state_next_s = DONE;
         default: state_next_s = IDLE;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r         <= {(WIDTH+1){1'b0}};
         b_r         <= {(WIDTH+1){1'b0}};
         r_r         <= {(WIDTH+1){1'b0}};
         sq_r        <= 1'b0;
         sr_r        <= 1'b0;
         ovf_r       <= 1'b0;
         quotient    <= {WIDTH{1'b0}};
         remainder   <= {WIDTH{1'b0}};
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else if (accept_s && zero_div_s) begin
         quotient    <= {WIDTH{1'b1}};
         remainder   <= dividend;
         done        <= 1'b1;
         div_by_zero <= 1'b1;
         overflow    <= 1'b0;
      end else if (accept_s) begin
         q_r         <= mag(dividend);
         b_r         <= mag(divisor);
         r_r         <= {(WIDTH+1){1'b0}};
         sq_r        <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         sr_r        <= dividend[WIDTH-1];
         ovf_r       <= ovf_s;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else if (state_r == ITER) begin
         r_r <= trial_ok_s ? r_diff_s : r_shift_s;
         q_r <= {1'b0, q_r[WIDTH-2:0], trial_ok_s};
      end else if (state_r == FIX) begin
         quotient  <= q_fix_s[WIDTH-1:0];
         remainder <= r_fix_s[WIDTH-1:0];
         overflow  <= ovf_r;
         done      <= 1'b1;
      end else begin
         done <= done;
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=16).
module tb_seq_divider;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = 16'd0;
   logic [W-1:0] divisor = 16'd0;
   logic [W-1:0] quotient, remainder;
   logic         done, div_by_zero, overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .done        (done),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   // Drives one start pulse; returns #1 after the accepting edge.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Edges after the start edge until done is seen; -1 when the budget runs out.
   task automatic wait_done(input int k0, output int lat);
      int k;
      lat = -1;
      k = k0;
      while (k <= 40) begin
         if (done === 1'b1) begin
            lat = k;
            break;
         end
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({quotient, remainder, done, div_by_zero, overflow} !== {(2*W+3){1'b0}}) begin
         errors++;
         $display("FAIL reset_state: got q=%h r=%h d=%b z=%b o=%b, want all 0",
                  quotient, remainder, done, div_by_zero, overflow);
      end
   endtask

   task automatic test_basic();
      int lat;
      launch(16'd100, 16'd7);
      wait_done(0, lat);
      checks++;
      if (lat !== 17) begin
         errors++;
         $display("FAIL basic_latency: got %0d, want 17", lat);
      end
      checks++;
      if ({quotient, remainder, div_by_zero, overflow} !== {16'd14, 16'd2, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL basic_result: got q=%0d r=%0d z=%b o=%b, want q=14 r=2 z=0 o=0",
                  $signed(quotient), $signed(remainder), div_by_zero, overflow);
      end
   endtask

   task automatic test_hold();
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({done, quotient, remainder} !== {1'b1, 16'd14, 16'd2}) begin
         errors++;
         $display("FAIL hold_done: got d=%b q=%0d r=%0d, want d=1 q=14 r=2",
                  done, $signed(quotient), $signed(remainder));
      end
   endtask

   task automatic test_signs();
      logic [W-1:0] va [3] = '{-16'sd100, 16'sd100, -16'sd100};
      logic [W-1:0] vb [3] = '{16'sd7, -16'sd7, -16'sd7};
      logic [W-1:0] eq [3] = '{-16'sd14, -16'sd14, 16'sd14};
      logic [W-1:0] er [3] = '{-16'sd2, 16'sd2, -16'sd2};
      int lat;
      for (int i = 0; i < 3; i++) begin
         launch(va[i], vb[i]);
         wait_done(0, lat);
         checks++;
         if ({lat == 17, quotient, remainder} !== {1'b1, eq[i], er[i]}) begin
            errors++;
            $display("FAIL signs_%0d: got lat=%0d q=%0d r=%0d, want lat=17 q=%0d r=%0d", i, lat,
                     $signed(quotient), $signed(remainder), $signed(eq[i]), $signed(er[i]));
         end
      end
   endtask

   task automatic test_overflow();
      int lat;
      launch(16'h8000, 16'hFFFF);
      wait_done(0, lat);
      checks++;
      if ({lat == 17, quotient, remainder, overflow, div_by_zero} !== {1'b1, 16'h8000, 16'h0000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL overflow_min_by_m1: got lat=%0d q=%h r=%h o=%b z=%b, want lat=17 q=8000 r=0000 o=1 z=0",
                  lat, quotient, remainder, overflow, div_by_zero);
      end
      launch(16'h8000, 16'd3);
      wait_done(0, lat);
      checks++;
      if ({lat == 17, quotient, remainder, overflow} !== {1'b1, -16'sd10922, -16'sd2, 1'b0}) begin
         errors++;
         $display("FAIL min_by_3: got lat=%0d q=%0d r=%0d o=%b, want lat=17 q=-10922 r=-2 o=0",
                  lat, $signed(quotient), $signed(remainder), overflow);
      end
   endtask

   task automatic test_div_zero();
      int lat;
      launch(16'd5, 16'd0);
      wait_done(0, lat);
      checks++;
      if (lat !== 0) begin
         errors++;
         $display("FAIL div0_latency: got %0d edges after start, want 0 (done at the start edge)", lat);
      end
      checks++;
      if ({quotient, remainder, div_by_zero, overflow} !== {16'hFFFF, 16'd5, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL div0_result: got q=%h r=%h z=%b o=%b, want q=ffff r=0005 z=1 o=0",
                  quotient, remainder, div_by_zero, overflow);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      launch(16'd1000, 16'd10);
      checks++;
      if ({done, div_by_zero} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_done_drop: got d=%b z=%b at start edge, want d=0 z=0", done, div_by_zero);
      end
      wait_done(0, lat);
      checks++;
      if ({lat == 17, quotient, remainder} !== {1'b1, 16'd100, 16'd0}) begin
         errors++;
         $display("FAIL b2b_result: got lat=%0d q=%0d r=%0d, want lat=17 q=100 r=0",
                  lat, $signed(quotient), $signed(remainder));
      end
   endtask

   task automatic test_start_ignored();
      int lat;
      @(negedge clk);
      dividend = 16'd100;
      divisor  = 16'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      dividend = 16'd9;
      divisor  = 16'd3;
      repeat (5) @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(5, lat);
      checks++;
      if ({lat == 17, quotient, remainder} !== {1'b1, 16'd14, 16'd2}) begin
         errors++;
         $display("FAIL start_ignored: got lat=%0d q=%0d r=%0d, want lat=17 q=14 r=2",
                  lat, $signed(quotient), $signed(remainder));
      end
   endtask

   task automatic test_reset_mid_iter();
      launch(16'd1000, 16'd10);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({quotient, remainder, done, div_by_zero, overflow} !== {(2*W+3){1'b0}}) begin
         errors++;
         $display("FAIL reset_mid_iter: got q=%h r=%h d=%b z=%b o=%b, want all 0",
                  quotient, remainder, done, div_by_zero, overflow);
      end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if ({quotient, remainder, done} !== {(2*W+1){1'b0}}) begin
         errors++;
         $display("FAIL reset_no_late_result: got q=%h r=%h d=%b, want all 0", quotient, remainder, done);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_signs();
      test_overflow();
      test_div_zero();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid_iter();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
